aha_sram_port_arbiter: RTL and testbench

- Shares the single-port 64-bit TLX SRAM model between two requesters: port 0 (AXI-to-SRAM converter) and port 1 (preload/backdoor DMA engine).
- Round-robin arbitration with bounded burst tenure, so one requester can stream beats back to back without starving the other.
- Muxes requests onto the SRAM port and routes 1-cycle-latency read data back to the requester that issued the read.
- Sits between the requesters and the SRAM instance in the TLX memory domain.

---
 rtl/aha_tlx_mem_pkg.sv | 24 ++
 rtl/aha_rr_tenure_fsm.sv | 112 +++++++++++
 rtl/aha_sram_port_arbiter.sv | 93 +++++++++
 tb/tb_aha_sram_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aha_tlx_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aha_tlx_mem_pkg
// Description : Shared TLX memory-domain types and default SRAM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package aha_tlx_mem_pkg;

  // Default TLX SRAM geometry (64-bit words)
  localparam int unsigned TLX_ADDR_WIDTH = 27;
  localparam int unsigned TLX_DATA_WIDTH = 64;

  // Tenure beat counter is 8 bits wide and saturates here
  localparam logic [7:0] BEAT_CNT_SAT = 8'hFF;

  // Arbiter ownership state
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/aha_rr_tenure_fsm.sv
`default_nettype none
// ============================================================================
// Module      : aha_rr_tenure_fsm
// Description : Two-port round-robin arbiter with bounded burst tenure.
//               Grants are combinational; ownership hands over with no bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module aha_rr_tenure_fsm
  import aha_tlx_mem_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  localparam logic [7:0] MAX_BURST_CNT = 8'(MAX_BURST);

  arb_state_e state_q, state_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       last_owner_q, last_owner_d;
  logic       burst_done;

  // Tenure is used up once the owner has taken MAX_BURST beats
  assign burst_done = (beat_cnt_q >= MAX_BURST_CNT);

  // State register; last_owner resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB_IDLE;
      beat_cnt_q   <= 8'd0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state: follow whichever grant was issued this cycle
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt0_o) begin
          state_d    = ARB_OWN0;
          beat_cnt_d = 8'd1;
        end else if (gnt1_o) begin
          state_d    = ARB_OWN1;
          beat_cnt_d = 8'd1;
        end
      end
      ARB_OWN0: begin
        if (gnt0_o) begin
          if (beat_cnt_q != BEAT_CNT_SAT) beat_cnt_d = beat_cnt_q + 8'd1;
        end else begin
          state_d      = gnt1_o ? ARB_OWN1 : ARB_IDLE;
          beat_cnt_d   = gnt1_o ? 8'd1 : 8'd0;
          last_owner_d = 1'b0;
        end
      end
      ARB_OWN1: begin
        if (gnt1_o) begin
          if (beat_cnt_q != BEAT_CNT_SAT) beat_cnt_d = beat_cnt_q + 8'd1;
        end else begin
          state_d      = gnt0_o ? ARB_OWN0 : ARB_IDLE;
          beat_cnt_d   = gnt0_o ? 8'd1 : 8'd0;
          last_owner_d = 1'b1;
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        beat_cnt_d = 8'd0;
      end
    endcase
  end

  // Grant outputs: owner keeps the port until it drops or its tenure expires under contention
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        gnt0_o = req0_i & (~req1_i | last_owner_q);
        gnt1_o = req1_i & (~req0_i | ~last_owner_q);
      end
      ARB_OWN0: begin
        gnt0_o = req0_i & (~burst_done | ~req1_i);
        gnt1_o = req1_i & (~req0_i | burst_done);
      end
      ARB_OWN1: begin
        gnt1_o = req1_i & (~burst_done | ~req0_i);
        gnt0_o = req0_i & (~req1_i | burst_done);
      end
      default: begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
      end
    endcase
    // No grant may escape while reset is asserted
    gnt0_o = gnt0_o & rst_ni;
    gnt1_o = gnt1_o & rst_ni;
  end

endmodule
`default_nettype wire

// File: rtl/aha_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aha_sram_port_arbiter
// Description : Shares one single-port TLX SRAM between two requesters:
//               request mux, read-return routing and contention statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module aha_sram_port_arbiter
  import aha_tlx_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = TLX_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = TLX_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    REQ0,
  input  logic                    REQ1,
  input  logic [ADDR_WIDTH-1:0]   ADDR0,
  input  logic [ADDR_WIDTH-1:0]   ADDR1,
  input  logic [DATA_WIDTH/8-1:0] WE0,
  input  logic [DATA_WIDTH/8-1:0] WE1,
  input  logic [DATA_WIDTH-1:0]   WDATA0,
  input  logic [DATA_WIDTH-1:0]   WDATA1,
  output logic                    GNT0,
  output logic                    GNT1,
  output logic                    RVALID0,
  output logic                    RVALID1,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    SRAM_CS,
  output logic [DATA_WIDTH/8-1:0] SRAM_WE,
  output logic [ADDR_WIDTH-1:0]   SRAM_ADDR,
  output logic [DATA_WIDTH-1:0]   SRAM_WDATA,
  input  logic [DATA_WIDTH-1:0]   SRAM_RDATA,
  output logic [CNT_WIDTH-1:0]    CONTENTION_CNT
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                 rvalid0_q, rvalid0_d;
  logic                 rvalid1_q, rvalid1_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  aha_rr_tenure_fsm #(
    .MAX_BURST (MAX_BURST)
  ) u_tenure_fsm (
    .clk_i  (ACLK),
    .rst_ni (ARESETn),
    .req0_i (REQ0),
    .req1_i (REQ1),
    .gnt0_o (GNT0),
    .gnt1_o (GNT1)
  );

  // SRAM request mux; port 0 drives address/data when nobody is granted
  always_comb begin
    SRAM_CS    = (REQ0 & GNT0) | (REQ1 & GNT1);
    SRAM_ADDR  = GNT1 ? ADDR1  : ADDR0;
    SRAM_WDATA = GNT1 ? WDATA1 : WDATA0;
    SRAM_WE    = {BE_WIDTH{1'b0}};
    if (SRAM_CS) SRAM_WE = GNT1 ? WE1 : WE0;
  end

  // Read-return tags and contention counter next values
  always_comb begin
    rvalid0_d = REQ0 & GNT0 & ~(|WE0);
    rvalid1_d = REQ1 & GNT1 & ~(|WE1);
    cnt_d     = cnt_q;
    if (((REQ0 & ~GNT0) | (REQ1 & ~GNT1)) && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // Response and statistics registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      cnt_q     <= {CNT_WIDTH{1'b0}};
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      cnt_q     <= cnt_d;
    end
  end

  assign RVALID0        = rvalid0_q;
  assign RVALID1        = rvalid1_q;
  assign RDATA          = SRAM_RDATA;
  assign CONTENTION_CNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aha_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aha_sram_port_arbiter
// Description : Self-checking bench for aha_sram_port_arbiter with an SRAM
//               model and a transaction-level arbitration reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aha_sram_port_arbiter;

  localparam int AW = 27;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int MB = 8;
  localparam int CW = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          REQ0 = 1'b0, REQ1 = 1'b0;
  logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
  logic [BW-1:0] WE0 = '0, WE1 = '0;
  logic [DW-1:0] WDATA0 = '0, WDATA1 = '0;
  logic          GNT0, GNT1, RVALID0, RVALID1, SRAM_CS;
  logic [DW-1:0] RDATA, SRAM_WDATA;
  logic [BW-1:0] SRAM_WE;
  logic [AW-1:0] SRAM_ADDR;
  logic [DW-1:0] sram_rdata = '0;
  logic [CW-1:0] CONTENTION_CNT;

  always #5 ACLK = ~ACLK;

  aha_sram_port_arbiter #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MAX_BURST (MB), .CNT_WIDTH (CW)
  ) dut (
    .ACLK (ACLK), .ARESETn (ARESETn),
    .REQ0 (REQ0), .REQ1 (REQ1), .ADDR0 (ADDR0), .ADDR1 (ADDR1),
    .WE0 (WE0), .WE1 (WE1), .WDATA0 (WDATA0), .WDATA1 (WDATA1),
    .GNT0 (GNT0), .GNT1 (GNT1), .RVALID0 (RVALID0), .RVALID1 (RVALID1),
    .RDATA (RDATA), .SRAM_CS (SRAM_CS), .SRAM_WE (SRAM_WE),
    .SRAM_ADDR (SRAM_ADDR), .SRAM_WDATA (SRAM_WDATA),
    .SRAM_RDATA (sram_rdata), .CONTENTION_CNT (CONTENTION_CNT)
  );

  function automatic logic [63:0] pre_word(input int i);
    return {32'(i) * 32'h9E3779B9, 32'hA5A5_0000 | 32'(i)};
  endfunction

  // Single-port SRAM model, 64 words, 1-cycle read latency
  logic [63:0] sram_mem [64];
  logic        sram_filled = 1'b0;
  always @(posedge ACLK) begin
    if (!sram_filled) begin
      for (int i = 0; i < 64; i++) sram_mem[i] <= pre_word(i);
      sram_filled <= 1'b1;
    end else if (SRAM_CS) begin
      if (SRAM_WE != '0) begin
        for (int b = 0; b < BW; b++)
          if (SRAM_WE[b]) sram_mem[SRAM_ADDR[5:0]][b*8 +: 8] <= SRAM_WDATA[b*8 +: 8];
      end else begin
        sram_rdata <= sram_mem[SRAM_ADDR[5:0]];
      end
    end
  end

  // Reference model state: owner is -1 (nobody) or the port index
  int          m_owner, m_beats, m_last, m_cnt;
  bit          m_rv0, m_rv1;
  logic [63:0] m_rdata;
  logic [63:0] ref_mem [64];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_last = 1; m_cnt = 0; m_rv0 = 0; m_rv1 = 0;
  endtask

  // Which port should be served given the current owner and requests
  function automatic int model_pick();
    int x, o;
    bit rx, ro;
    if (m_owner < 0) begin
      if (REQ0 && REQ1) return 1 - m_last;
      if (REQ0) return 0;
      if (REQ1) return 1;
      return -1;
    end
    x  = m_owner;
    o  = 1 - x;
    rx = (x == 1) ? REQ1 : REQ0;
    ro = (x == 1) ? REQ0 : REQ1;
    if (rx && (m_beats < MB || !ro)) return x;
    if (ro) return o;
    return -1;
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs
  task automatic step(input logic q0, input logic q1, input logic [5:0] ad0, input logic [5:0] ad1,
                      input logic [7:0] e0, input logic [7:0] e1,
                      input logic [63:0] wd0, input logic [63:0] wd1,
                      output int gm, output int gd);
    int          g;
    logic [5:0]  ga;
    logic [7:0]  ge;
    logic [63:0] gwd;
    REQ0 = q0; REQ1 = q1;
    ADDR0 = {21'd0, ad0}; ADDR1 = {21'd0, ad1};
    WE0 = e0; WE1 = e1; WDATA0 = wd0; WDATA1 = wd1;
    #2;
    g   = model_pick();
    gm  = g;
    gd  = GNT1 ? 1 : (GNT0 ? 0 : -1);
    ga  = (g == 1) ? ad1 : ad0;
    ge  = (g == 1) ? e1  : e0;
    gwd = (g == 1) ? wd1 : wd0;
    check("gnt0", GNT0, g == 0);
    check("gnt1", GNT1, g == 1);
    check("sram_cs", SRAM_CS, g >= 0);
    if (g >= 0) begin
      check("sram_addr", SRAM_ADDR, {21'd0, ga});
      check("sram_we", SRAM_WE, ge);
      check("sram_wdata", SRAM_WDATA, gwd);
    end else begin
      check("sram_we_idle", SRAM_WE, 0);
    end
    @(posedge ACLK);
    if (((q0 && g != 0) || (q1 && g != 1)) && m_cnt < 65535) m_cnt++;
    m_rv0 = 0; m_rv1 = 0;
    if (g >= 0) begin
      if (ge == 0) begin
        if (g == 0) m_rv0 = 1; else m_rv1 = 1;
        m_rdata = ref_mem[ga];
      end else begin
        for (int b = 0; b < BW; b++) if (ge[b]) ref_mem[ga][b*8 +: 8] = gwd[b*8 +: 8];
      end
    end
    if (g < 0) begin
      if (m_owner >= 0) m_last = m_owner;
      m_owner = -1; m_beats = 0;
    end else if (g == m_owner) begin
      if (m_beats < 255) m_beats++;
    end else begin
      if (m_owner >= 0) m_last = m_owner;
      m_owner = g; m_beats = 1;
    end
    #1;
    check("rvalid0", RVALID0, m_rv0);
    check("rvalid1", RVALID1, m_rv1);
    if (m_rv0 || m_rv1) check("rdata", RDATA, m_rdata);
    check("contention_cnt", CONTENTION_CNT, m_cnt);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0; WE0 = '0; WE1 = '0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          gm, gd;
    logic [63:0] pw;
    bit          p0, p1;
    logic [5:0]  pa0, pa1;
    logic [7:0]  pe0, pe1;
    logic [63:0] pd0, pd1;

    for (int i = 0; i < 64; i++) ref_mem[i] = pre_word(i);
    model_reset();
    do_reset();
    check("reset_rvalid0", RVALID0, 0);
    check("reset_rvalid1", RVALID1, 0);
    check("reset_cnt", CONTENTION_CNT, 0);
    check("reset_cs", SRAM_CS, 0);

    // Single read from port 0
    step(1, 0, 6'h10, 6'h00, 8'h00, 8'h00, '0, '0, gm, gd);
    check("t1_gnt", 64'(gd), 64'(0));
    check("t1_rvalid0", RVALID0, 1);
    check("t1_rdata", RDATA, pre_word(16));
    step(0, 0, 6'h00, 6'h00, 8'h00, 8'h00, '0, '0, gm, gd);
    check("t1_cnt", CONTENTION_CNT, 0);

    // Tie from IDLE after reset, then hand-over with no bubble
    do_reset();
    step(1, 1, 6'h01, 6'h02, 8'h00, 8'h00, '0, '0, gm, gd);
    check("t2_first", 64'(gd), 64'(0));
    step(0, 1, 6'h01, 6'h02, 8'h00, 8'h00, '0, '0, gm, gd);
    check("t2_second", 64'(gd), 64'(1));
    step(0, 0, 6'h00, 6'h00, 8'h00, 8'h00, '0, '0, gm, gd);
    check("t2_cnt", CONTENTION_CNT, 1);

    // Continuous contention: 8 x port0, 8 x port1, 4 x port0
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 6'(i), 6'(i + 32), 8'h00, 8'h00, '0, '0, gm, gd);
      check("burst_gnt", 64'(gd), (i >= 8 && i < 16) ? 64'(1) : 64'(0));
      if (i == 7) begin
        check("switch_rvalid0", RVALID0, 1);
        check("switch_rvalid1", RVALID1, 0);
      end
    end
    check("burst_cnt", CONTENTION_CNT, 20);
    step(0, 0, 6'h00, 6'h00, 8'h00, 8'h00, '0, '0, gm, gd);

    // Partial write from port 0, read back from port 1
    do_reset();
    step(1, 0, 6'h03, 6'h00, 8'h0F, 8'h00, 64'hDEADBEEF_CAFEF00D, '0, gm, gd);
    step(0, 1, 6'h00, 6'h03, 8'h00, 8'h00, '0, '0, gm, gd);
    pw = pre_word(3);
    check("t4_rvalid1", RVALID1, 1);
    check("t4_rdata", RDATA, {pw[63:32], 32'hCAFEF00D});
    step(0, 0, 6'h00, 6'h00, 8'h00, 8'h00, '0, '0, gm, gd);

    // Asynchronous reset while a read response is pending
    do_reset();
    step(1, 0, 6'h05, 6'h00, 8'h00, 8'h00, '0, '0, gm, gd);
    check("t6_rvalid_before", RVALID0, 1);
    #1;
    REQ0 = 1'b1; REQ1 = 1'b1;
    ARESETn = 1'b0;
    #1;
    check("t6_rvalid0", RVALID0, 0);
    check("t6_gnt0", GNT0, 0);
    check("t6_gnt1", GNT1, 0);
    check("t6_cs", SRAM_CS, 0);
    check("t6_cnt", CONTENTION_CNT, 0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    model_reset();
    step(1, 1, 6'h06, 6'h07, 8'h00, 8'h00, '0, '0, gm, gd);
    check("t6_tie", 64'(gd), 64'(0));
    step(0, 0, 6'h00, 6'h00, 8'h00, 8'h00, '0, '0, gm, gd);

    // Randomized traffic; requests are held until granted
    do_reset();
    p0 = 0; p1 = 0;
    pa0 = '0; pa1 = '0; pe0 = '0; pe1 = '0; pd0 = '0; pd1 = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!p0 && $urandom_range(99) < 60) begin
        p0 = 1; pa0 = 6'($urandom_range(63));
        pe0 = ($urandom_range(1) == 1) ? 8'($urandom) : 8'h00;
        pd0 = {$urandom, $urandom};
      end
      if (!p1 && $urandom_range(99) < 60) begin
        p1 = 1; pa1 = 6'($urandom_range(63));
        pe1 = ($urandom_range(1) == 1) ? 8'($urandom) : 8'h00;
        pd1 = {$urandom, $urandom};
      end
      step(p0, p1, pa0, pa1, pe0, pe1, pd0, pd1, gm, gd);
      if (gm == 0) p0 = 0;
      if (gm == 1) p1 = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
